regfile_arbiter: RTL and testbench

//  Shares the GPIO/ID register file between two requesters: port 0 (CPU core) and port 1 (debug/SPI host).

---
 rtl/regfile_arbiter_pkg.sv | 37 +++
 rtl/regfile_arbiter_if.sv | 39 +++
 rtl/regfile_arbiter_rr_arb2.sv | 30 +++
 rtl/regfile_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the GPIO/ID register-file arbiter: FSM encodings,
// register map constants and the access-legality check.
package regfile_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int ADDR_CNAME    = 0;
  localparam int ADDR_CVERSION = 1;
  localparam int MAX_ADDR_DEF  = 81;

  // Register map: two ID registers, then 16 banks of 5 registers each.
  localparam int BANK_BASE    = 2;
  localparam int NUM_BANKS    = 16;
  localparam int BANK_REGS    = 5;
  localparam int OFS_DATA_OUT = 0;
  localparam int OFS_DIR      = 1;
  localparam int OFS_DATA_IN  = 2;
  localparam int OFS_IRQ_EN   = 3;
  localparam int OFS_IRQ_STAT = 4;

  function automatic int bank_reg_addr(input int bank, input int ofs);
    return BANK_BASE + bank * BANK_REGS + ofs;
  endfunction

  // ID registers are read-only; anything past the last bank does not exist.
  function automatic logic access_illegal(input logic [15:0] addr,
                                          input logic        r_wn,
                                          input logic [15:0] max_addr);
    return (addr > max_addr) || (!r_wn && (addr <= 16'(ADDR_CVERSION)));
  endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Bundle of both requester ports plus the register-file strobe bus.
// Handshake: req is held with stable fields until gnt (one-cycle accept); done
// (one cycle) completes the access with err and rdata valid in that cycle.
interface regfile_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  import regfile_arbiter_pkg::*;

  logic              req0,   req1;
  logic              r_wn0,  r_wn1;
  logic [ADDR_W-1:0] addr0,  addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0,   gnt1;
  logic              done0,  done1;
  logic              err0,   err1;
  logic [DATA_W-1:0] rdata0, rdata1;

  logic              rf_en;
  logic              rf_r_wn;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;

  state_t            dbg_state;

  modport master (
    output req0, req1, r_wn0, r_wn1, addr0, addr1, wdata0, wdata1, rf_rdata,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           rf_en, rf_r_wn, rf_addr, rf_wdata, dbg_state
  );

  modport slave (
    input  req0, req1, r_wn0, r_wn1, addr0, addr1, wdata0, wdata1, rf_rdata,
    output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           rf_en, rf_r_wn, rf_addr, rf_wdata, dbg_state
  );

endinterface

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin picker. The pointer remembers the last served port and
// resets to 1 so that port 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    last_d = upd ? upd_id : last_q;
    grant  = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the GPIO/ID register file between the CPU port (0) and the debug port
// (1): round-robin pick, one access in flight, registered strobes and responses.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_ADDR_DEF),
  parameter int                RD_LAT   = 1
) (
  input logic              clk,
  input logic              rst_n,
  regfile_arbiter_if.slave bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            state_q, state_d;
  logic              id_q, id_d;
  logic              r_wn_q, r_wn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ill_q, ill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              rf_en_q, rf_en_d;
  logic              rf_r_wn_q, rf_r_wn_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic [1:0]        arb_grant;
  logic              arb_upd;
  logic              sel_id, sel_r_wn, sel_ill;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              fin, fin_err, fin_load;
  logic [DATA_W-1:0] fin_data;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({bus.req1, bus.req0}),
    .upd    (arb_upd),
    .upd_id (id_q),
    .grant  (arb_grant)
  );

  assign sel_id    = arb_grant[1];
  assign sel_r_wn  = sel_id ? bus.r_wn1  : bus.r_wn0;
  assign sel_addr  = sel_id ? bus.addr1  : bus.addr0;
  assign sel_wdata = sel_id ? bus.wdata1 : bus.wdata0;
  assign sel_ill   = access_illegal(16'(sel_addr), sel_r_wn, 16'(MAX_ADDR));

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    r_wn_d     = r_wn_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ill_d      = ill_q;
    cnt_d      = cnt_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rf_en_d    = 1'b0;
    rf_r_wn_d  = rf_r_wn_q;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    arb_upd    = 1'b0;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_load   = 1'b0;
    fin_data   = '0;

    case (state_q)
      S_IDLE: begin
        if (|arb_grant) begin
          id_d    = sel_id;
          r_wn_d  = sel_r_wn;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          ill_d   = sel_ill;
          gnt0_d  = arb_grant[0];
          gnt1_d  = arb_grant[1];
          // Outputs are registered, so the strobe is set on entry to ISSUE.
          if (!sel_ill) begin
            rf_en_d    = 1'b1;
            rf_r_wn_d  = sel_r_wn;
            rf_addr_d  = sel_addr;
            rf_wdata_d = sel_wdata;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!ill_q && r_wn_q) begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = S_WAIT;
        end else begin
          // Rejected reads return zero; writes never touch rdata.
          fin      = 1'b1;
          fin_err  = ill_q;
          fin_load = r_wn_q;
          state_d  = S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          fin      = 1'b1;
          fin_load = 1'b1;
          fin_data = bus.rf_rdata;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        arb_upd = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      if (id_q) begin
        done1_d = 1'b1;
        err1_d  = fin_err;
        if (fin_load) rdata1_d = fin_data;
      end else begin
        done0_d = 1'b1;
        err0_d  = fin_err;
        if (fin_load) rdata0_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      id_q       <= 1'b0;
      r_wn_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ill_q      <= 1'b0;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rf_en_q    <= 1'b0;
      rf_r_wn_q  <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      r_wn_q     <= r_wn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ill_q      <= ill_d;
      cnt_q      <= cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rf_en_q    <= rf_en_d;
      rf_r_wn_q  <= rf_r_wn_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.rf_en     = rf_en_q;
  assign bus.rf_r_wn   = rf_r_wn_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a vector table of single accesses, hand-written
// multi-cycle sequences, and a per-port expected-response queue checked on done.
module tb_regfile_arbiter;
  import regfile_arbiter_pkg::*;

  localparam logic [31:0] CNAME = 32'h4348_4950;
  localparam logic [31:0] CVER  = 32'h0001_0002;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();
  regfile_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus3 ();

  regfile_arbiter #(.RD_LAT(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  regfile_arbiter #(.RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Register file model for the RD_LAT=1 instance: registered read.
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (bus.rf_en && !bus.rf_r_wn) mem[bus.rf_addr] <= bus.rf_wdata;
    if (bus.rf_en && bus.rf_r_wn)
      bus.rf_rdata <= (bus.rf_addr == 7'd0) ? CNAME :
                      (bus.rf_addr == 7'd1) ? CVER  : mem[bus.rf_addr];
  end

  // RD_LAT=3 model: 0x1234 only in the third cycle after rf_en, junk otherwise.
  logic [1:0] p3 = 2'b00;
  always @(posedge clk) begin
    p3 <= {p3[0], bus3.rf_en};
    bus3.rf_rdata <= p3[1] ? 32'h0000_1234 : 32'hFFFF_0000;
  end

  typedef struct {
    int          port;
    logic        r_wn;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        exp_rf;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [14];
  logic [32:0] exp0_q [$];
  logic [32:0] exp1_q [$];
  logic [31:0] sh_rd [2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Advance to the next falling edge and score any completions on the main DUT.
  task automatic tick();
    logic [32:0] e;
    @(negedge clk);
    if (bus.done0) begin
      if (exp0_q.size() == 0) fail("done0 unexpected");
      else begin
        e = exp0_q.pop_front();
        check("done0 err", bus.err0, e[32]);
        check("done0 rdata", bus.rdata0, e[31:0]);
      end
    end
    if (bus.done1) begin
      if (exp1_q.size() == 0) fail("done1 unexpected");
      else begin
        e = exp1_q.pop_front();
        check("done1 err", bus.err1, e[32]);
        check("done1 rdata", bus.rdata1, e[31:0]);
      end
    end
  endtask

  task automatic push_exp(input int port, input logic r_wn, input logic err, input logic [31:0] rd);
    logic [31:0] e;
    e = r_wn ? (err ? 32'h0 : rd) : sh_rd[port];
    sh_rd[port] = e;
    if (port == 0) exp0_q.push_back({err, e});
    else           exp1_q.push_back({err, e});
  endtask

  task automatic drive(input int port, input logic req, input logic r_wn,
                       input logic [6:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0 = req; bus.r_wn0 = r_wn; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = req; bus.r_wn1 = r_wn; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  task automatic wait_gnt(input int port, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      tick();
      ok = (port == 0) ? bus.gnt0 : bus.gnt1;
    end
    if (!ok) fail("gnt timeout");
  endtask

  task automatic wait_done(input int port);
    for (int k = 0; k < 30 && ((port == 0) ? exp0_q.size() : exp1_q.size()) != 0; k++) tick();
    if (((port == 0) ? exp0_q.size() : exp1_q.size()) != 0) begin
      fail("done timeout");
      if (port == 0) exp0_q.delete();
      else           exp1_q.delete();
    end
  endtask

  task automatic do_access(input vec_t v);
    bit ok;
    push_exp(v.port, v.r_wn, v.exp_err, v.exp_rdata);
    drive(v.port, 1'b1, v.r_wn, v.addr, v.wdata);
    wait_gnt(v.port, ok);
    if (ok) begin
      check("rf_en at gnt", bus.rf_en, v.exp_rf);
      if (v.exp_rf) begin
        check("rf_r_wn", bus.rf_r_wn, v.r_wn);
        check("rf_addr", bus.rf_addr, v.addr);
        if (!v.r_wn) check("rf_wdata", bus.rf_wdata, v.wdata);
      end
    end
    drive(v.port, 1'b0, v.r_wn, v.addr, v.wdata);
    wait_done(v.port);
    tick();
  endtask

  task automatic check_reset(input string name);
    check({name, " gnt"},   {bus.gnt1, bus.gnt0}, 2'b00);
    check({name, " done"},  {bus.done1, bus.done0}, 2'b00);
    check({name, " err"},   {bus.err1, bus.err0}, 2'b00);
    check({name, " rdata0"}, bus.rdata0, 32'h0);
    check({name, " rdata1"}, bus.rdata1, 32'h0);
    check({name, " rf_en"},  bus.rf_en, 1'b0);
    check({name, " rf_r_wn"}, bus.rf_r_wn, 1'b0);
    check({name, " rf_addr"}, bus.rf_addr, 7'h0);
    check({name, " rf_wdata"}, bus.rf_wdata, 32'h0);
    check({name, " state"},  bus.dbg_state, S_IDLE);
  endtask

  initial begin
    bit ok;
    int exp_port;
    int ngnt;
    vec_t v;

    vecs[0]  = '{0, 1'b0, 7'd2,   32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{0, 1'b1, 7'd2,   32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 1'b0, 7'd0,   32'h5,         1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1, 1'b0, 7'd82,  32'h6,         1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1, 1'b0, 7'd81,  32'hA5A5_0081, 1'b0, 1'b1, 32'h0};
    vecs[5]  = '{1, 1'b1, 7'd81,  32'h0,         1'b0, 1'b1, 32'hA5A5_0081};
    vecs[6]  = '{1, 1'b0, 7'd1,   32'h7,         1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1, 1'b1, 7'd82,  32'h0,         1'b1, 1'b0, 32'h0};
    vecs[8]  = '{0, 1'b1, 7'd0,   32'h0,         1'b0, 1'b1, CNAME};
    vecs[9]  = '{1, 1'b1, 7'd1,   32'h0,         1'b0, 1'b1, CVER};
    vecs[10] = '{0, 1'b1, 7'd127, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[11] = '{0, 1'b0, 7'd127, 32'h9,         1'b1, 1'b0, 32'h0};
    vecs[12] = '{0, 1'b0, 7'd3,   32'h1122_3344, 1'b0, 1'b1, 32'h0};
    vecs[13] = '{0, 1'b1, 7'd3,   32'h0,         1'b0, 1'b1, 32'h1122_3344};

    sh_rd[0] = 32'h0;
    sh_rd[1] = 32'h0;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 7'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 7'd0, 32'h0);
    bus3.req0 = 1'b0; bus3.r_wn0 = 1'b0; bus3.addr0 = 7'd0; bus3.wdata0 = 32'h0;
    bus3.req1 = 1'b0; bus3.r_wn1 = 1'b0; bus3.addr1 = 7'd0; bus3.wdata1 = 32'h0;

    repeat (3) @(negedge clk);
    check_reset("reset");
    check("reset dut3 outputs", {bus3.gnt0, bus3.done0, bus3.rf_en, bus3.rdata0}, 35'h0);
    rst_n = 1'b1;
    tick();

    // Single accesses: legal/illegal reads and writes on both ports.
    for (int i = 0; i < 14; i++) do_access(vecs[i]);

    // Port 1 request rising during port 0's ISSUE is served only after IDLE.
    push_exp(0, 1'b0, 1'b0, 32'h0);
    drive(0, 1'b1, 1'b0, 7'd4, 32'h0BAD_F00D);
    wait_gnt(0, ok);
    drive(0, 1'b0, 1'b0, 7'd4, 32'h0BAD_F00D);
    drive(1, 1'b1, 1'b1, 7'd4, 32'h0);
    push_exp(1, 1'b1, 1'b0, 32'h0BAD_F00D);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t6 gnt1 cycle", bus.gnt1, (k == 3));
    end
    check("t6 done0 seen", exp0_q.size(), 0);
    drive(1, 1'b0, 1'b1, 7'd4, 32'h0);
    wait_done(1);
    tick();

    // Make port 0 the last served, then abort a port 0 read in WAIT.
    v = '{0, 1'b1, 7'd2, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    do_access(v);
    drive(0, 1'b1, 1'b1, 7'd2, 32'h0);
    wait_gnt(0, ok);
    drive(0, 1'b0, 1'b1, 7'd2, 32'h0);
    tick();
    check("t5 in wait", bus.dbg_state, S_WAIT);
    rst_n = 1'b0;
    #1;
    check_reset("t5 abort");
    sh_rd[0] = 32'h0;
    sh_rd[1] = 32'h0;
    drive(0, 1'b1, 1'b1, 7'd3, 32'h0);
    drive(1, 1'b1, 1'b1, 7'd3, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Both ports requesting from reset: port 0 first, then strict alternation.
    exp_port = 0;
    ngnt = 0;
    for (int k = 0; k < 200 && ngnt < 20; k++) begin
      tick();
      if (bus.gnt0 || bus.gnt1) begin
        check("t2 grant port", {bus.gnt1, bus.gnt0}, (exp_port == 1) ? 2'b10 : 2'b01);
        push_exp(exp_port, 1'b1, 1'b0, 32'h1122_3344);
        exp_port = 1 - exp_port;
        ngnt++;
      end
    end
    check("t2 grant count", ngnt, 20);
    drive(0, 1'b0, 1'b1, 7'd3, 32'h0);
    drive(1, 1'b0, 1'b1, 7'd3, 32'h0);
    wait_done(0);
    wait_done(1);
    tick();

    // RD_LAT=3: done lands in the sixth cycle counting the sample cycle, i.e.
    // four falling edges after the gnt cycle.
    bus3.req0 = 1'b1; bus3.r_wn0 = 1'b1; bus3.addr0 = 7'd5;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      tick();
      ok = bus3.gnt0;
    end
    if (!ok) fail("t4 gnt timeout");
    bus3.req0 = 1'b0;
    check("t4 rf_en", bus3.rf_en, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("t4 done timing", bus3.done0, (j == 4));
    end
    check("t4 rdata", bus3.rdata0, 32'h0000_1234);
    check("t4 err", bus3.err0, 1'b0);
    tick();
    check("t4 done single", bus3.done0, 1'b0);
    check("t4 rdata held", bus3.rdata0, 32'h0000_1234);

    check("final q0 empty", exp0_q.size(), 0);
    check("final q1 empty", exp1_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
